// File: rtl/piezo_tune_seq_pkg.sv
// piezo_pkg: shared types and constants for the piezo tune sequencer.
//   seq_state_t  - sequencer states (IDLE, PLAY, GAP)
//   NOTE_*       - note periods fed to the piezo frequency counter
//   TUNE_LEN     - number of notes in the tune
//   note_entry_t - one tune ROM entry {per, dur}
package piezo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } seq_state_t;

   localparam logic [14:0] NOTE_G6 = 15'd31888;
   localparam logic [14:0] NOTE_C7 = 15'd23889;
   localparam logic [14:0] NOTE_E7 = 15'd18960;

   localparam int unsigned TUNE_LEN = 4;

   typedef struct packed {
      logic [14:0] per;
      logic [1:0]  dur;
   } note_entry_t;

endpackage

// File: rtl/piezo_tune_seq_if.sv
// piezo_tune_seq_if: control/output bundle of the piezo tune sequencer.
//   start, abort      - from the system control FSM
//   note_per, clr     - to the piezo frequency counter
//   busy, done        - status back to the system control FSM
// modport slave  : the sequencer side
// modport master : the controller / consumer side
interface piezo_tune_seq_if;

   logic        start;
   logic        abort;
   logic [14:0] note_per;
   logic        clr;
   logic        busy;
   logic        done;

   modport slave (
      input  start,
      input  abort,
      output note_per,
      output clr,
      output busy,
      output done
   );

   modport master (
      output start,
      output abort,
      input  note_per,
      input  clr,
      input  busy,
      input  done
   );

endinterface

// File: rtl/piezo_tune_seq_rom.sv
// piezo_tune_rom: combinational tune table.
//   i_idx   - 2-bit note index
//   o_entry - {note period, duration in units}
module piezo_tune_rom
   import piezo_pkg::*;
(
   input  logic [1:0]  i_idx,
   output note_entry_t o_entry
);

   always_comb begin
      o_entry = '0;
      unique case (i_idx)
         2'd0:    o_entry = '{per: NOTE_G6, dur: 2'd1};
         2'd1:    o_entry = '{per: NOTE_C7, dur: 2'd1};
         2'd2:    o_entry = '{per: NOTE_E7, dur: 2'd1};
         default: o_entry = '{per: NOTE_G6, dur: 2'd2};
      endcase
   end

endmodule

// File: rtl/piezo_tune_seq.sv
// piezo_tune_seq: plays a fixed four-note tune (G6, C7, E7, G6-long) with
// silent gaps between notes, driving note_per/clr of the piezo counter.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - piezo_tune_seq_if.slave (start, abort, note_per, clr, busy, done)
// Parameters: DUR_SHIFT (duration unit = 2^DUR_SHIFT cycles), GAP_CYC (gap length).
// Build option: define PIEZO_FAST_SIM_EN to force a duration shift of 6.
module piezo_tune_seq
   import piezo_pkg::*;
#(
   parameter int unsigned DUR_SHIFT = 22,
   parameter int unsigned GAP_CYC   = 1048576
)(
   input  logic             clk,
   input  logic             rst,
   piezo_tune_seq_if.slave  bus
);

`ifdef PIEZO_FAST_SIM_EN
   localparam int unsigned EFF_SHIFT = 6;
`else
   localparam int unsigned EFF_SHIFT = DUR_SHIFT;
`endif

   localparam logic [23:0] GAP_LAST = 24'(GAP_CYC - 1);

   seq_state_t  r_state;
   logic [1:0]  r_note_idx;
   logic [24:0] r_dur_cnt;
   logic [23:0] r_gap_cnt;
   logic        r_done;

   seq_state_t  w_state_nxt;
   logic [1:0]  w_note_idx_nxt;
   logic [24:0] w_dur_cnt_nxt;
   logic [23:0] w_gap_cnt_nxt;
   logic        w_done_nxt;

   note_entry_t w_entry;
   logic [24:0] w_dur_last;
   logic        w_dur_tc;
   logic        w_gap_tc;

   piezo_tune_rom u_rom (
      .i_idx   (r_note_idx),
      .o_entry (w_entry)
   );

   // Terminal count of the current note, formed in the full 25-bit width.
   assign w_dur_last = (25'(w_entry.dur) << EFF_SHIFT) - 25'd1;
   assign w_dur_tc   = (r_dur_cnt == w_dur_last);
   assign w_gap_tc   = (r_gap_cnt == GAP_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_note_idx <= '0;
         r_dur_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_note_idx <= w_note_idx_nxt;
         r_dur_cnt  <= w_dur_cnt_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_note_idx_nxt = r_note_idx;
      w_dur_cnt_nxt  = r_dur_cnt;
      w_gap_cnt_nxt  = r_gap_cnt;
      w_done_nxt     = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_note_idx_nxt = '0;
            w_dur_cnt_nxt  = '0;
            w_gap_cnt_nxt  = '0;
            if (bus.start) begin
               w_state_nxt = PLAY;
            end
         end
         PLAY: begin
            if (w_dur_tc) begin
               if (r_note_idx == 2'(TUNE_LEN - 1)) begin
                  w_state_nxt    = IDLE;
                  w_note_idx_nxt = '0;
                  w_done_nxt     = 1'b1;
               end else begin
                  w_state_nxt   = GAP;
                  w_gap_cnt_nxt = '0;
               end
            end else begin
               w_dur_cnt_nxt = r_dur_cnt + 25'd1;
            end
         end
         GAP: begin
            if (w_gap_tc) begin
               w_state_nxt    = PLAY;
               w_note_idx_nxt = r_note_idx + 2'd1;
               w_dur_cnt_nxt  = '0;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 24'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Abort overrides every transition above, including a same-cycle done.
      if (bus.abort) begin
         w_state_nxt    = IDLE;
         w_note_idx_nxt = '0;
         w_dur_cnt_nxt  = '0;
         w_gap_cnt_nxt  = '0;
         w_done_nxt     = 1'b0;
      end
   end

   assign bus.note_per = (r_state == PLAY) ? w_entry.per : '0;
   assign bus.clr      = (r_state != PLAY);
   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = r_done;

endmodule

// File: tb/tb_piezo_tune_seq.sv
module tb_piezo_tune_seq;

   localparam int unsigned UNIT = 64;
   localparam int unsigned GAP  = 4;
   localparam int unsigned TOTAL = 5 * UNIT + 3 * GAP;

   typedef struct packed {
      logic [14:0] per;
      logic        clr;
      logic        busy;
      logic        done;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   piezo_tune_seq_if u_if ();

   piezo_tune_seq #(
      .DUR_SHIFT (6),
      .GAP_CYC   (GAP)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   obs_t        exp_q[$];

   // Reference model: tune as a list of notes and gaps in time.
   bit          m_active = 1'b0;
   int unsigned m_t      = 0;
   bit          m_done   = 1'b0;

   function automatic obs_t expect_now();
      obs_t        o;
      int unsigned off;
      int unsigned per [4];
      int unsigned dur [4];
      per = '{31888, 23889, 18960, 31888};
      dur = '{1, 1, 1, 2};
      o = '{per: 15'd0, clr: 1'b1, busy: 1'b0, done: m_done};
      if (m_active) begin
         o.busy = 1'b1;
         o.done = 1'b0;
         off = 0;
         for (int i = 0; i < 4; i++) begin
            if (m_t <= off + dur[i] * UNIT) begin
               o.per = 15'(per[i]);
               o.clr = 1'b0;
               return o;
            end
            off += dur[i] * UNIT;
            if (i < 3) begin
               if (m_t <= off + GAP) return o;
               off += GAP;
            end
         end
      end
      return o;
   endfunction

   function automatic void model_edge(input bit s, input bit a, input bit r);
      if (r || a) begin
         m_active = 1'b0;
         m_t      = 0;
         m_done   = 1'b0;
      end else if (m_active) begin
         m_t++;
         if (m_t == TOTAL + 1) begin
            m_active = 1'b0;
            m_t      = 0;
            m_done   = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (s) begin
            m_active = 1'b1;
            m_t      = 1;
         end
      end
   endfunction

   task automatic step(input bit s, input bit a, input bit r);
      u_if.start = s;
      u_if.abort = a;
      rst        = r;
      @(posedge clk);
      #1;
      model_edge(s, a, r);
      exp_q.push_back(expect_now());
      cyc++;
   endtask

   // Monitor: one observation per cycle, compared against the queue head.
   always @(negedge clk) begin
      obs_t got, want;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = '{per: u_if.note_per, clr: u_if.clr, busy: u_if.busy, done: u_if.done};
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL cyc%0d: got per=%0d clr=%0d busy=%0d done=%0d, want per=%0d clr=%0d busy=%0d done=%0d",
                     cyc, got.per, got.clr, got.busy, got.done, want.per, want.clr, want.busy, want.done);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.start = 1'b0;
      u_if.abort = 1'b0;

      // Reset held two cycles, then idle.
      step(0, 0, 1);
      step(0, 0, 1);
      repeat (3) step(0, 0, 0);

      // Full tune with an ignored start while busy at +50.
      step(1, 0, 0);
      for (int i = 1; i <= TOTAL + 3; i++) step(i == 50, 0, 0);

      // Start and abort together in IDLE.
      step(1, 1, 0);
      repeat (3) step(0, 0, 0);

      // Abort at +100.
      step(1, 0, 0);
      for (int i = 1; i < 100; i++) step(0, 0, 0);
      step(0, 1, 0);
      repeat (TOTAL) step(0, 0, 0);

      // Back-to-back: start in the done cycle.
      step(1, 0, 0);
      for (int i = 0; i < 1000 && !m_done; i++) step(0, 0, 0);
      step(1, 0, 0);
      repeat (TOTAL + 3) step(0, 0, 0);

      // Abort exactly on the final terminal count (no done).
      step(1, 0, 0);
      for (int i = 1; i < TOTAL; i++) step(0, 0, 0);
      step(0, 1, 0);
      repeat (3) step(0, 0, 0);

      // Reset mid-tune.
      step(1, 0, 0);
      repeat (70) step(0, 0, 0);
      step(0, 0, 1);
      repeat (3) step(0, 0, 0);

      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 399) == 0,
              $urandom_range(0, 1499) == 0);
      end
      repeat (2) step(0, 0, 0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
